// File: rtl/dram_bus_arbiter.sv
// Shared DRAM pin-bus arbiter: init writer, AES read path and a periodic refresh scheduler.
// All outputs are registered from next-state values so the pin mux sees glitch-free selects.
module dram_bus_arbiter #(
  parameter int REF_PERIOD    = 4096,
  parameter int REF_LEN       = 64,
  parameter int REF_MAX_DEFER = 256,
  parameter int GUARD         = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INIT_REQ,
  input  logic       INIT_REL,
  input  logic       AES_REQ,
  input  logic       AES_REL,
  output logic       INIT_GNT,
  output logic       AES_GNT,
  output logic       PREEMPT,
  output logic [1:0] SEL,
  output logic       REF_WWL,
  output logic [5:0] REF_ROW,
  output logic [7:0] REF_MISS
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_G_INIT  = 3'd1;
  localparam logic [2:0] S_G_AES   = 3'd2;
  localparam logic [2:0] S_REFRESH = 3'd3;
  localparam logic [2:0] S_GUARD   = 3'd4;

  localparam int PW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int DW = $clog2(REF_MAX_DEFER + 1);
  localparam int TW = $clog2(((REF_LEN > GUARD) ? REF_LEN : GUARD) + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(REF_PERIOD - 1);
  localparam logic [DW-1:0] DEFER_MAX   = DW'(REF_MAX_DEFER);
  localparam logic [TW-1:0] REF_LAST    = TW'(REF_LEN - 1);
  localparam logic [TW-1:0] GUARD_LAST  = TW'(GUARD - 1);

  logic [2:0]    state, state_nxt;
  logic [PW-1:0] period_cnt;
  logic [DW-1:0] defer_cnt, defer_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          pending, pending_nxt;
  logic          wrap, defer_full, ref_entry, ref_exit, miss;
  logic [1:0]    sel_nxt;

  assign wrap       = (period_cnt == PERIOD_LAST);
  assign defer_full = (defer_cnt == DEFER_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pending && defer_full) state_nxt = S_REFRESH;
        else if (INIT_REQ)         state_nxt = S_G_INIT;
        else if (pending)          state_nxt = S_REFRESH;
        else if (AES_REQ)          state_nxt = S_G_AES;
      end
      S_G_INIT:  if (INIT_REL)            state_nxt = S_GUARD;
      S_G_AES:   if (AES_REL)             state_nxt = S_GUARD;
      S_REFRESH: if (timer == REF_LAST)   state_nxt = S_GUARD;
      S_GUARD:   if (timer == GUARD_LAST) state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // Refresh bookkeeping: a wrap on the entry edge itself is a fresh request, not a miss.
  always_comb begin
    ref_entry   = (state == S_IDLE) && (state_nxt == S_REFRESH);
    ref_exit    = (state == S_REFRESH) && (state_nxt == S_GUARD);
    miss        = wrap && pending && !ref_entry;
    pending_nxt = pending;
    if (wrap)           pending_nxt = 1'b1;
    else if (ref_entry) pending_nxt = 1'b0;
    defer_nxt = defer_cnt;
    if (ref_entry)                    defer_nxt = '0;
    else if (pending && !defer_full)  defer_nxt = defer_cnt + 1'b1;
    timer_nxt = '0;
    if ((state_nxt == state) && ((state == S_REFRESH) || (state == S_GUARD)))
      timer_nxt = timer + 1'b1;
    case (state_nxt)
      S_G_INIT:  sel_nxt = 2'b01;
      S_G_AES:   sel_nxt = 2'b10;
      S_REFRESH: sel_nxt = 2'b11;
      default:   sel_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      period_cnt <= '0;
      pending    <= 1'b0;
      defer_cnt  <= '0;
      timer      <= '0;
      INIT_GNT   <= 1'b0;
      AES_GNT    <= 1'b0;
      PREEMPT    <= 1'b0;
      SEL        <= 2'b00;
      REF_WWL    <= 1'b0;
      REF_ROW    <= 6'd0;
      REF_MISS   <= 8'd0;
    end else begin
      state      <= state_nxt;
      period_cnt <= wrap ? '0 : period_cnt + 1'b1;
      pending    <= pending_nxt;
      defer_cnt  <= defer_nxt;
      timer      <= timer_nxt;
      if (ref_exit)                   REF_ROW  <= REF_ROW + 6'd1;
      if (miss && (REF_MISS != 8'hFF)) REF_MISS <= REF_MISS + 8'd1;
      INIT_GNT <= (state_nxt == S_G_INIT);
      AES_GNT  <= (state_nxt == S_G_AES);
      REF_WWL  <= (state_nxt == S_REFRESH);
      SEL      <= sel_nxt;
      PREEMPT  <= (defer_nxt == DEFER_MAX) &&
                  ((state_nxt == S_G_INIT) || (state_nxt == S_G_AES));
    end
  end

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Bench for dram_bus_arbiter: directed scenarios plus random traffic, all compared each cycle
// against a time-stamp based reference model of the arbitration rules.
module tb_dram_bus_arbiter;
  localparam int P    = 100;
  localparam int RLEN = 4;
  localparam int MAXD = 10;
  localparam int GRD  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_req, init_rel, aes_req, aes_rel;
  logic       init_gnt, aes_gnt, preempt, ref_wwl;
  logic [1:0] sel;
  logic [5:0] ref_row;
  logic [7:0] ref_miss;
  logic [19:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Model: owner 0 idle, 1 init, 2 aes, 3 refresh, 4 guard; times are cycles since reset.
  int m_t, m_own, m_ref_t, m_g_t, m_pend, m_pend_t, m_row, m_miss;

  dram_bus_arbiter #(.REF_PERIOD(P), .REF_LEN(RLEN), .REF_MAX_DEFER(MAXD), .GUARD(GRD)) dut (
    .CLK(clk), .RST(rst),
    .INIT_REQ(init_req), .INIT_REL(init_rel), .AES_REQ(aes_req), .AES_REL(aes_rel),
    .INIT_GNT(init_gnt), .AES_GNT(aes_gnt), .PREEMPT(preempt), .SEL(sel),
    .REF_WWL(ref_wwl), .REF_ROW(ref_row), .REF_MISS(ref_miss)
  );

  always #5 clk = ~clk;

  assign dut_vec = {init_gnt, aes_gnt, preempt, sel, ref_wwl, ref_row, ref_miss};

  function automatic int m_defer();
    int d;
    if (m_pend == 0) return 0;
    d = m_t - m_pend_t;
    return (d > MAXD) ? MAXD : d;
  endfunction

  function automatic logic [19:0] exp_vec();
    logic       pre;
    logic [1:0] s;
    logic [5:0] r;
    logic [7:0] ms;
    pre = ((m_own == 1) || (m_own == 2)) && (m_defer() == MAXD);
    s   = (m_own >= 1 && m_own <= 3) ? 2'(m_own) : 2'b00;
    r   = 6'(m_row);
    ms  = 8'(m_miss);
    return {m_own == 1, m_own == 2, pre, s, m_own == 3, r, ms};
  endfunction

  task automatic model_reset();
    m_t = 0; m_own = 0; m_ref_t = 0; m_g_t = 0;
    m_pend = 0; m_pend_t = 0; m_row = 0; m_miss = 0;
  endtask

  task automatic model_step();
    int  d, nown;
    bit  wrap, entering;
    d    = m_defer();
    wrap = ((m_t % P) == P - 1);
    nown = m_own;
    case (m_own)
      0: begin
        if (m_pend != 0 && d == MAXD) nown = 3;
        else if (init_req)            nown = 1;
        else if (m_pend != 0)         nown = 3;
        else if (aes_req)             nown = 2;
      end
      1: if (init_rel) begin nown = 4; m_g_t = m_t + 1; end
      2: if (aes_rel)  begin nown = 4; m_g_t = m_t + 1; end
      3: if (m_t - m_ref_t == RLEN - 1) begin
           nown = 4; m_g_t = m_t + 1; m_row = (m_row + 1) % 64;
         end
      default: if (m_t - m_g_t == GRD - 1) nown = 0;
    endcase
    entering = (m_own == 0) && (nown == 3);
    if (entering) m_ref_t = m_t + 1;
    if (wrap) begin
      if (m_pend != 0 && !entering) begin
        if (m_miss < 255) m_miss++;
      end else begin
        m_pend_t = m_t + 1;
      end
      m_pend = 1;
    end else if (entering) begin
      m_pend = 0;
    end
    m_own = nown;
    m_t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    init_req = 0; init_rel = 0; aes_req = 0; aes_rel = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_req = 0; init_rel = 0; aes_req = 0; aes_rel = 0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++; $display("FAIL reset_outputs got=%h want=%h", dut_vec, 20'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_init_then_aes();
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      init_req = (c >= 5 && c < 8);
      init_rel = (c == 20);
      aes_req  = (c >= 10 && c <= 30);
      aes_rel  = (c == 27 || c == 38);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL init_aes_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
      if (c + 1 == 6) begin
        checks++;
        if (init_gnt !== 1'b1 || sel !== 2'b01) begin
          errors++; $display("FAIL init_grant_c6 got gnt=%b sel=%b want gnt=1 sel=01", init_gnt, sel);
        end
      end
      if (c + 1 == 21 || c + 1 == 22) begin
        checks++;
        if (sel !== 2'b00 || init_gnt !== 1'b0) begin
          errors++; $display("FAIL guard_idle cyc=%0d got sel=%b want 00", c + 1, sel);
        end
      end
      if (c + 1 == 24 || c + 1 == 31) begin
        checks++;
        if (aes_gnt !== 1'b1 || sel !== 2'b10) begin
          errors++; $display("FAIL aes_grant cyc=%0d got gnt=%b sel=%b want gnt=1 sel=10", c + 1, aes_gnt, sel);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int r;
    do_reset();
    r = $urandom_range(20, 8);
    for (int c = 0; c <= r + 15; c++) begin
      init_req = (c >= 3);
      aes_req  = (c >= 3);
      init_rel = (c == r);
      aes_rel  = (c == r + 10);
      if (c > r) init_req = 1'b0;
      step();
      checks++;
      if (dut_vec !== exp_vec() || (init_gnt && aes_gnt)) begin
        errors++; $display("FAIL simul_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
      if (c + 1 == 4) begin
        checks++;
        if (init_gnt !== 1'b1 || aes_gnt !== 1'b0) begin
          errors++; $display("FAIL simul_init_first got init=%b aes=%b want init=1 aes=0", init_gnt, aes_gnt);
        end
      end
      if (c + 1 == r + 4) begin
        checks++;
        if (aes_gnt !== 1'b1) begin
          errors++; $display("FAIL simul_aes_after_guard cyc=%0d got=%b want=1", c + 1, aes_gnt);
        end
      end
    end
  endtask

  task automatic test_refresh_rotation();
    do_reset();
    for (int c = 0; c <= 6410; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL refresh_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
      if (c + 1 >= 100 && c + 1 <= 105) begin
        checks++;
        if (ref_wwl !== ((c + 1 >= 101 && c + 1 <= 104) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL refresh_window cyc=%0d got wwl=%b", c + 1, ref_wwl);
        end
      end
      if (c + 1 == 105 || c + 1 == 6305 || c + 1 == 6405) begin
        checks++;
        if (ref_row !== ((c + 1 == 105) ? 6'd1 : (c + 1 == 6305) ? 6'd63 : 6'd0)) begin
          errors++; $display("FAIL refresh_row cyc=%0d got=%0d", c + 1, ref_row);
        end
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    for (int c = 0; c <= 135; c++) begin
      aes_req  = 1'b1;
      init_req = (c >= 112 && c < 126);
      aes_rel  = (c == 115);
      init_rel = (c == 128);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL preempt_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
      if (c + 1 == 109 || c + 1 == 110 || c + 1 == 116) begin
        checks++;
        if (preempt !== ((c + 1 == 110) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL preempt_level cyc=%0d got=%b", c + 1, preempt);
        end
      end
      if (c + 1 == 119) begin
        checks++;
        if (ref_wwl !== 1'b1 || sel !== 2'b11) begin
          errors++; $display("FAIL preempt_refresh_first got wwl=%b sel=%b want wwl=1 sel=11", ref_wwl, sel);
        end
      end
      if (c + 1 == 126) begin
        checks++;
        if (init_gnt !== 1'b1) begin
          errors++; $display("FAIL preempt_then_init got=%b want=1", init_gnt);
        end
      end
    end
  endtask

  task automatic test_miss();
    do_reset();
    for (int c = 0; c <= 25700; c++) begin
      aes_req = 1'b1;
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL miss_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
      if (c + 1 == 199 || c + 1 == 200 || c + 1 == 300 || c + 1 == 25600 || c + 1 == 25701) begin
        checks++;
        if (ref_miss !== ((c + 1 == 199) ? 8'd0 : (c + 1 == 200) ? 8'd1 :
                          (c + 1 == 300) ? 8'd2 : 8'd255)) begin
          errors++; $display("FAIL miss_count cyc=%0d got=%0d", c + 1, ref_miss);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c <= 301; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL async_pre_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
    end
    checks++;
    if (ref_wwl !== 1'b1 || ref_row !== 6'd2) begin
      errors++; $display("FAIL async_in_refresh got wwl=%b row=%0d want wwl=1 row=2", ref_wwl, ref_row);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++; $display("FAIL async_reset_refresh got=%h want=%h", dut_vec, 20'h0);
    end
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      aes_req = 1'b1;
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL async_aes_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
      if (c + 1 == 1) begin
        checks++;
        if (aes_gnt !== 1'b1 || ref_row !== 6'd0) begin
          errors++; $display("FAIL async_first_grant got gnt=%b row=%0d want gnt=1 row=0", aes_gnt, ref_row);
        end
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++; $display("FAIL async_reset_aes got=%h want=%h", dut_vec, 20'h0);
    end
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      init_req = (c == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec() || (c == 0 && init_gnt !== 1'b1)) begin
        errors++; $display("FAIL async_init_regrant cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 6 == 0) init_req = ~init_req;
      if ($urandom % 6 == 0) aes_req  = ~aes_req;
      init_rel = ($urandom % 14 == 0);
      aes_rel  = ($urandom % 14 == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec() || (init_gnt && aes_gnt)) begin
        errors++; $display("FAIL random_model cyc=%0d got=%h want=%h", c + 1, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_then_aes();
    test_simultaneous();
    test_refresh_rotation();
    test_preempt();
    test_miss();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
